ysyx_25060170_ifu_fetch: RTL and testbench
==========================================

// Module: ysyx_25060170_ifu_fetch
// PURPOSE
//  Instruction-fetch stage. Holds the PC, fetches one 32-bit instruction per
//  request over an AXI4-Lite read channel, and presents {pc,inst} to the
//  IF/ID register with a valid/ready handshake.
//  Accepts redirects from ID, EX and LS; discards any in-flight wrong-path fetch.
// PARAMETERS
//  RESET_PC  32'h8000_0000  PC of first fetch after reset release
//  XLEN      32             PC / address / instruction width
// PORTS
//  clk         in   1     clock; all state on rising edge
//  rst         in   1     asynchronous, active-low reset
//  id_pc_jump  in   1     ID redirect request
//  id_pc_i     in   XLEN  ID redirect target
//  ie_pc_jump  in   1     EX redirect request
//  ie_pc_i     in   XLEN  EX redirect target
//  ls_pc_jump  in   1     LS redirect request
//  ls_pc_i     in   XLEN  LS redirect target
//  id_stall    in   1     ID load-use stall; blocks handoff like !id_ready
//  id_ready    in   1     IF/ID register can accept
//  if_valid    out  1     pc_o/inst_o valid this cycle
//  pc_o        out  XLEN  PC of presented instruction
//  inst_o      out  32    presented instruction
//  fetch_err   out  1     presented instruction had RRESP!=OKAY
//  araddr      out  XLEN  AXI read address (= fetch PC)
//  arvalid     out  1     AXI read address valid
//  arready     in   1     AXI read address ready
//  rdata       in   32    AXI read data
//  rresp       in   2     AXI read response
//  rvalid      in   1     AXI read data valid
//  rready      out  1     AXI read data ready
// BEHAVIOUR
//  Reset (rst=0): state=S_IDLE, pc=RESET_PC, kill=0. Outputs 0: if_valid,
//   arvalid, rready, fetch_err, inst_o. araddr=RESET_PC. Applies immediately,
//   also mid-transaction; the bench bus is reset with the core.
//  Redirect priority (same cycle): ls > ie > id; one target latched.
//  FSM:
//   S_IDLE: 1 cycle after reset release -> S_AR.
//   S_AR: arvalid=1, araddr=pc. On arvalid&arready -> S_R.
//    arvalid/araddr are never dropped before arready (AXI rule).
//    A redirect here updates pc and sets kill=1.
//   S_R: rready=1. On rvalid:
//    kill=1 -> discard, kill=0, -> S_AR at the new pc.
//    else latch inst_o=rdata, fetch_err=(rresp!=0) -> S_HOLD.
//    A redirect in the rvalid cycle counts as kill.
//   S_HOLD: if_valid=1.
//    Redirect -> if_valid=0 next cycle, pc=target -> S_AR. The instruction
//     is dropped even if id_ready=1.
//    Else if id_ready & !id_stall -> handoff, pc=pc+4 (wraps mod 2^32) -> S_AR.
//    Else hold; pc_o/inst_o stable.
//  Latency: min 3 cycles per instruction (AR, R, HOLD); no overlap of requests.
//  Redirect target bits [1:0] are passed through unchanged; misalignment is
//   handled elsewhere.
//  At most one AXI read outstanding at any time.
// STRUCTURE
//  Shared package (define.v): state encodings S_IDLE/S_AR/S_R/S_HOLD,
//   RESET_PC default, AXI RESP_OKAY.
//  One natural sub-module: ysyx_25060170_ifu_redirect_arb (combinational
//   3-way priority select -> {redir_valid, redir_pc}).
//  FSM and pc/kill/output registers live in this module.
// TESTING
//  1 Release reset, arready=rvalid=1 always, id_ready=1 -> araddr
//    80000000, 80000004, 80000008; one if_valid pulse per 3 cycles.
//  2 id_ready=0 for 5 cycles in S_HOLD -> if_valid, pc_o, inst_o stable;
//    no new arvalid. Then id_ready=1 -> next araddr=pc+4.
//  3 ie_pc_jump=1 to 80000100 while in S_R, rvalid delayed 4 cycles ->
//    old rdata never seen on if_valid; next araddr=80000100.
//  4 id, ie and ls all jump in the same cycle (targets 200/300/400) ->
//    next araddr=80000400.
//  5 arready=0 for 3 cycles and redirect asserted -> araddr held until
//    accepted; response discarded; refetch at the target.
//  6 rresp=2'b10 -> fetch_err=1 with if_valid. Drive rst=0 mid-S_R ->
//    arvalid/rready/if_valid=0 immediately; restart at 80000000.

Source files
------------

// File: rtl/ysyx_25060170_ifu_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encodings,
// reset PC default and AXI response codes.
package ysyx_25060170_ifu_fetch_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_AR   = 2'd1,
      S_R    = 2'd2,
      S_HOLD = 2'd3
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
   localparam logic [1:0]  RESP_OKAY    = 2'b00;

endpackage

// File: rtl/ysyx_25060170_ifu_fetch_if.sv
// AXI4-Lite read channel between the fetch stage (master) and the
// instruction memory (slave).
interface ysyx_25060170_ifu_fetch_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] araddr;
   logic            arvalid;
   logic            arready;
   logic [31:0]     rdata;
   logic [1:0]      rresp;
   logic            rvalid;
   logic            rready;

   modport master (
      output araddr, arvalid, rready,
      input  arready, rdata, rresp, rvalid
   );

   modport slave (
      input  araddr, arvalid, rready,
      output arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/ysyx_25060170_ifu_redirect_arb.sv
// Fixed-priority select among the three redirect sources; the oldest
// instruction in the pipe (LS) wins over EX, which wins over ID.
module ysyx_25060170_ifu_redirect_arb #(
   parameter int XLEN = 32
) (
   input  logic            id_pc_jump,
   input  logic [XLEN-1:0] id_pc_i,
   input  logic            ie_pc_jump,
   input  logic [XLEN-1:0] ie_pc_i,
   input  logic            ls_pc_jump,
   input  logic [XLEN-1:0] ls_pc_i,
   output logic            redir_valid,
   output logic [XLEN-1:0] redir_pc
);

   always_comb begin
      redir_valid = ls_pc_jump | ie_pc_jump | id_pc_jump;
      redir_pc    = id_pc_i;
      if (ls_pc_jump)      redir_pc = ls_pc_i;
      else if (ie_pc_jump) redir_pc = ie_pc_i;
   end

endmodule

// File: rtl/ysyx_25060170_ifu_fetch.sv
// Instruction-fetch stage: one AXI4-Lite read per instruction, result
// presented to IF/ID with valid/ready; redirects kill wrong-path fetches.
module ysyx_25060170_ifu_fetch
   import ysyx_25060170_ifu_fetch_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_pc_jump,
   input  logic [XLEN-1:0]       id_pc_i,
   input  logic                  ie_pc_jump,
   input  logic [XLEN-1:0]       ie_pc_i,
   input  logic                  ls_pc_jump,
   input  logic [XLEN-1:0]       ls_pc_i,
   input  logic                  id_stall,
   input  logic                  id_ready,
   output logic                  if_valid,
   output logic [XLEN-1:0]       pc_o,
   output logic [31:0]           inst_o,
   output logic                  fetch_err,
   ysyx_25060170_ifu_fetch_if.master axi
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] araddr_q, araddr_d;
   logic            kill_q, kill_d;
   logic [31:0]     inst_q;
   logic            err_q;
   logic            cap;
   logic            redir_valid;
   logic [XLEN-1:0] redir_pc;

   ysyx_25060170_ifu_redirect_arb #(.XLEN(XLEN)) u_arb (
      .id_pc_jump  (id_pc_jump),
      .id_pc_i     (id_pc_i),
      .ie_pc_jump  (ie_pc_jump),
      .ie_pc_i     (ie_pc_i),
      .ls_pc_jump  (ls_pc_jump),
      .ls_pc_i     (ls_pc_i),
      .redir_valid (redir_valid),
      .redir_pc    (redir_pc)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         pc_q     <= RESET_PC;
         araddr_q <= RESET_PC;
         kill_q   <= 1'b0;
         inst_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         araddr_q <= araddr_d;
         kill_q   <= kill_d;
         if (cap) begin
            inst_q <= axi.rdata;
            err_q  <= (axi.rresp != RESP_OKAY);
         end
      end
   end

   // araddr_q is only reloaded when entering S_AR, so a redirect during
   // a stalled address phase changes pc_q but never the address on the bus.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      araddr_d = araddr_q;
      kill_d   = kill_q;
      cap      = 1'b0;
      case (state_q)
         S_IDLE: begin
            state_d = S_AR;
            if (redir_valid) pc_d = redir_pc;
            araddr_d = pc_d;
         end
         S_AR: begin
            if (redir_valid) begin
               pc_d   = redir_pc;
               kill_d = 1'b1;
            end
            if (axi.arready) state_d = S_R;
         end
         S_R: begin
            if (redir_valid) pc_d = redir_pc;
            if (axi.rvalid) begin
               if (kill_q || redir_valid) begin
                  kill_d   = 1'b0;
                  araddr_d = pc_d;
                  state_d  = S_AR;
               end else begin
                  cap     = 1'b1;
                  state_d = S_HOLD;
               end
            end else if (redir_valid) begin
               kill_d = 1'b1;
            end
         end
         S_HOLD: begin
            if (redir_valid) begin
               pc_d     = redir_pc;
               araddr_d = redir_pc;
               state_d  = S_AR;
            end else if (id_ready && !id_stall) begin
               pc_d     = pc_q + XLEN'(4);
               araddr_d = pc_q + XLEN'(4);
               state_d  = S_AR;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign axi.araddr  = araddr_q;
   assign axi.arvalid = (state_q == S_AR);
   assign axi.rready  = (state_q == S_R);
   assign if_valid    = (state_q == S_HOLD);
   assign pc_o        = pc_q;
   assign inst_o      = inst_q;
   assign fetch_err   = err_q;

endmodule

// File: tb/tb_ysyx_25060170_ifu_fetch.sv
// Directed bench for the fetch stage with a small AXI read-slave model.
module tb_ysyx_25060170_ifu_fetch;

   logic        clk, rst;
   logic        id_pc_jump, ie_pc_jump, ls_pc_jump;
   logic [31:0] id_pc_i, ie_pc_i, ls_pc_i;
   logic        id_stall, id_ready;
   logic        if_valid, fetch_err;
   logic [31:0] pc_o, inst_o;

   logic        s_arready;
   int          s_rdelay;
   logic [1:0]  s_rresp;
   logic        s_pend;
   int          s_cnt;
   logic [31:0] s_addr;

   int          n_cmp, n_bad, cyc;
   logic [31:0] ar_q[$];
   logic [31:0] hs_pc[$];
   logic [31:0] hs_inst[$];
   int          hs_cyc[$];

   ysyx_25060170_ifu_fetch_if #(.XLEN(32)) axi ();

   ysyx_25060170_ifu_fetch dut (
      .clk        (clk),
      .rst        (rst),
      .id_pc_jump (id_pc_jump),
      .id_pc_i    (id_pc_i),
      .ie_pc_jump (ie_pc_jump),
      .ie_pc_i    (ie_pc_i),
      .ls_pc_jump (ls_pc_jump),
      .ls_pc_i    (ls_pc_i),
      .id_stall   (id_stall),
      .id_ready   (id_ready),
      .if_valid   (if_valid),
      .pc_o       (pc_o),
      .inst_o     (inst_o),
      .fetch_err  (fetch_err),
      .axi        (axi)
   );

   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign axi.arready = s_arready;
   assign axi.rvalid  = s_pend && (s_cnt == 0);
   assign axi.rdata   = mem(s_addr);
   assign axi.rresp   = s_rresp;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         s_pend <= 1'b0;
         s_cnt  <= 0;
         s_addr <= '0;
      end else begin
         if (axi.arvalid && axi.arready) begin
            s_pend <= 1'b1;
            s_cnt  <= s_rdelay;
            s_addr <= axi.araddr;
         end else if (axi.rvalid && axi.rready) begin
            s_pend <= 1'b0;
         end else if (s_pend && s_cnt != 0) begin
            s_cnt <= s_cnt - 1;
         end
      end
   end

   // Bus/handoff log; a handoff in a redirect cycle is dropped by the stage.
   always @(posedge clk) begin
      cyc++;
      if (rst && axi.arvalid && axi.arready) ar_q.push_back(axi.araddr);
      if (rst && if_valid && id_ready && !id_stall &&
          !(id_pc_jump || ie_pc_jump || ls_pc_jump)) begin
         hs_pc.push_back(pc_o);
         hs_inst.push_back(inst_o);
         hs_cyc.push_back(cyc);
      end
   end

   task automatic test_reset();
      rst = 1'b0;
      id_pc_jump = 0; ie_pc_jump = 0; ls_pc_jump = 0;
      id_pc_i = '0; ie_pc_i = '0; ls_pc_i = '0;
      id_stall = 0; id_ready = 1;
      s_arready = 1; s_rdelay = 0; s_rresp = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL reset_if_valid got %b exp 0", if_valid); end
      n_cmp++; if (axi.arvalid !== 1'b0) begin n_bad++; $display("FAIL reset_arvalid got %b exp 0", axi.arvalid); end
      n_cmp++; if (axi.rready !== 1'b0) begin n_bad++; $display("FAIL reset_rready got %b exp 0", axi.rready); end
      n_cmp++; if (fetch_err !== 1'b0) begin n_bad++; $display("FAIL reset_fetch_err got %b exp 0", fetch_err); end
      n_cmp++; if (inst_o !== 32'h0) begin n_bad++; $display("FAIL reset_inst got %h exp 0", inst_o); end
      n_cmp++; if (axi.araddr !== 32'h8000_0000) begin n_bad++; $display("FAIL reset_araddr got %h exp 80000000", axi.araddr); end
   endtask

   task automatic test_stream();
      ar_q.delete(); hs_pc.delete(); hs_inst.delete(); hs_cyc.delete();
      rst = 1'b1;
      for (int i = 0; i < 40 && hs_pc.size() < 3; i++) begin @(posedge clk); #1; end
      n_cmp++; if (hs_pc.size() < 3) begin n_bad++; $display("FAIL stream_timeout got %0d handoffs exp 3", hs_pc.size()); end
      else begin
         n_cmp++; if (ar_q[0] !== 32'h8000_0000) begin n_bad++; $display("FAIL stream_ar0 got %h exp 80000000", ar_q[0]); end
         n_cmp++; if (ar_q[1] !== 32'h8000_0004) begin n_bad++; $display("FAIL stream_ar1 got %h exp 80000004", ar_q[1]); end
         n_cmp++; if (ar_q[2] !== 32'h8000_0008) begin n_bad++; $display("FAIL stream_ar2 got %h exp 80000008", ar_q[2]); end
         n_cmp++; if (hs_pc[2] !== 32'h8000_0008) begin n_bad++; $display("FAIL stream_pc2 got %h exp 80000008", hs_pc[2]); end
         n_cmp++; if (hs_inst[0] !== 32'h9357_9BDF) begin n_bad++; $display("FAIL stream_inst0 got %h exp 93579bdf", hs_inst[0]); end
         n_cmp++; if (hs_cyc[1] - hs_cyc[0] != 3) begin n_bad++; $display("FAIL stream_period01 got %0d exp 3", hs_cyc[1] - hs_cyc[0]); end
         n_cmp++; if (hs_cyc[2] - hs_cyc[1] != 3) begin n_bad++; $display("FAIL stream_period12 got %0d exp 3", hs_cyc[2] - hs_cyc[1]); end
      end
   endtask

   task automatic test_stall();
      logic [31:0] p0;
      int n_ar;
      bit stable;
      id_ready = 0;
      for (int i = 0; i < 20 && !if_valid; i++) begin @(posedge clk); #1; end
      n_cmp++; if (pc_o !== 32'h8000_000C) begin n_bad++; $display("FAIL stall_pc got %h exp 8000000c", pc_o); end
      n_cmp++; if (inst_o !== mem(32'h8000_000C)) begin n_bad++; $display("FAIL stall_inst got %h exp %h", inst_o, mem(32'h8000_000C)); end
      p0 = pc_o; n_ar = ar_q.size(); stable = 1;
      repeat (5) begin
         @(posedge clk); #1;
         if (!if_valid || pc_o !== p0 || inst_o !== mem(p0) || axi.arvalid) stable = 0;
      end
      n_cmp++; if (!stable) begin n_bad++; $display("FAIL stall_hold got unstable exp stable pc %h", p0); end
      n_cmp++; if (ar_q.size() != n_ar) begin n_bad++; $display("FAIL stall_no_ar got %0d reads exp %0d", ar_q.size(), n_ar); end
      id_ready = 1;
      for (int i = 0; i < 20 && ar_q.size() <= n_ar; i++) begin @(posedge clk); #1; end
      n_cmp++; if (ar_q.size() <= n_ar || ar_q[n_ar] !== 32'h8000_0010) begin n_bad++; $display("FAIL stall_next_ar got %h exp 80000010", (ar_q.size() > n_ar) ? ar_q[n_ar] : 32'hx); end
   endtask

   task automatic test_kill_in_r();
      int n_ar, n_hs;
      s_rdelay = 4;
      for (int i = 0; i < 20 && !(axi.rready && !axi.rvalid); i++) begin @(posedge clk); #1; end
      n_ar = ar_q.size(); n_hs = hs_pc.size();
      ie_pc_jump = 1; ie_pc_i = 32'h8000_0100;
      @(posedge clk); #1;
      ie_pc_jump = 0;
      for (int i = 0; i < 20 && ar_q.size() <= n_ar; i++) begin @(posedge clk); #1; end
      n_cmp++; if (ar_q.size() <= n_ar || ar_q[n_ar] !== 32'h8000_0100) begin n_bad++; $display("FAIL kill_next_ar got %h exp 80000100", (ar_q.size() > n_ar) ? ar_q[n_ar] : 32'hx); end
      for (int i = 0; i < 30 && hs_pc.size() <= n_hs; i++) begin @(posedge clk); #1; end
      n_cmp++; if (hs_pc.size() <= n_hs || hs_pc[n_hs] !== 32'h8000_0100) begin n_bad++; $display("FAIL kill_handoff_pc got %h exp 80000100", (hs_pc.size() > n_hs) ? hs_pc[n_hs] : 32'hx); end
      n_cmp++; if (hs_inst.size() <= n_hs || hs_inst[n_hs] !== mem(32'h8000_0100)) begin n_bad++; $display("FAIL kill_handoff_inst got %h exp %h", (hs_inst.size() > n_hs) ? hs_inst[n_hs] : 32'hx, mem(32'h8000_0100)); end
      s_rdelay = 0;
   endtask

   task automatic test_prio();
      int n_hs;
      id_ready = 0;
      for (int i = 0; i < 20 && !if_valid; i++) begin @(posedge clk); #1; end
      n_cmp++; if (pc_o !== 32'h8000_0104) begin n_bad++; $display("FAIL prio_hold_pc got %h exp 80000104", pc_o); end
      // all three sources at once, with ID ready: the held instruction is dropped
      id_pc_jump = 1; id_pc_i = 32'h8000_0200;
      ie_pc_jump = 1; ie_pc_i = 32'h8000_0300;
      ls_pc_jump = 1; ls_pc_i = 32'h8000_0400;
      id_ready = 1;
      @(posedge clk); #1;
      id_pc_jump = 0; ie_pc_jump = 0; ls_pc_jump = 0; id_ready = 0;
      n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL prio_drop got if_valid %b exp 0", if_valid); end
      n_cmp++; if (axi.araddr !== 32'h8000_0400) begin n_bad++; $display("FAIL prio_ls_wins got %h exp 80000400", axi.araddr); end
      for (int i = 0; i < 20 && !if_valid; i++) begin @(posedge clk); #1; end
      n_cmp++; if (pc_o !== 32'h8000_0400 || inst_o !== mem(32'h8000_0400)) begin n_bad++; $display("FAIL prio_fetch got %h/%h exp 80000400/%h", pc_o, inst_o, mem(32'h8000_0400)); end
      id_pc_jump = 1; id_pc_i = 32'h8000_0200;
      ie_pc_jump = 1; ie_pc_i = 32'h8000_0300;
      @(posedge clk); #1;
      id_pc_jump = 0; ie_pc_jump = 0;
      n_cmp++; if (axi.araddr !== 32'h8000_0300) begin n_bad++; $display("FAIL prio_ie_wins got %h exp 80000300", axi.araddr); end
      n_hs = hs_pc.size();
      id_ready = 1;
      for (int i = 0; i < 20 && hs_pc.size() <= n_hs; i++) begin @(posedge clk); #1; end
      n_cmp++; if (hs_pc.size() <= n_hs || hs_pc[n_hs] !== 32'h8000_0300) begin n_bad++; $display("FAIL prio_handoff got %h exp 80000300", (hs_pc.size() > n_hs) ? hs_pc[n_hs] : 32'hx); end
   endtask

   task automatic test_ar_stall();
      int n_ar, n_hs;
      bit held;
      s_arready = 0;
      n_cmp++; if (axi.arvalid !== 1'b1 || axi.araddr !== 32'h8000_0304) begin n_bad++; $display("FAIL arstall_start got %b/%h exp 1/80000304", axi.arvalid, axi.araddr); end
      n_ar = ar_q.size(); n_hs = hs_pc.size();
      id_pc_jump = 1; id_pc_i = 32'h8000_0500;
      @(posedge clk); #1;
      id_pc_jump = 0;
      held = (axi.arvalid === 1'b1) && (axi.araddr === 32'h8000_0304);
      repeat (2) begin
         @(posedge clk); #1;
         if (axi.arvalid !== 1'b1 || axi.araddr !== 32'h8000_0304) held = 0;
      end
      n_cmp++; if (!held) begin n_bad++; $display("FAIL arstall_hold got %b/%h exp 1/80000304", axi.arvalid, axi.araddr); end
      s_arready = 1;
      for (int i = 0; i < 30 && ar_q.size() < n_ar + 2; i++) begin @(posedge clk); #1; end
      n_cmp++; if (ar_q.size() < n_ar + 2 || ar_q[n_ar] !== 32'h8000_0304) begin n_bad++; $display("FAIL arstall_old_ar got %h exp 80000304", (ar_q.size() > n_ar) ? ar_q[n_ar] : 32'hx); end
      n_cmp++; if (ar_q.size() < n_ar + 2 || ar_q[n_ar+1] !== 32'h8000_0500) begin n_bad++; $display("FAIL arstall_refetch got %h exp 80000500", (ar_q.size() > n_ar + 1) ? ar_q[n_ar+1] : 32'hx); end
      for (int i = 0; i < 20 && hs_pc.size() <= n_hs; i++) begin @(posedge clk); #1; end
      n_cmp++; if (hs_pc.size() <= n_hs || hs_pc[n_hs] !== 32'h8000_0500) begin n_bad++; $display("FAIL arstall_handoff got %h exp 80000500", (hs_pc.size() > n_hs) ? hs_pc[n_hs] : 32'hx); end
   endtask

   task automatic test_err_and_reset();
      s_rresp = 2'b10; id_ready = 0;
      for (int i = 0; i < 20 && !if_valid; i++) begin @(posedge clk); #1; end
      n_cmp++; if (pc_o !== 32'h8000_0504 || fetch_err !== 1'b1) begin n_bad++; $display("FAIL err_set got %h/%b exp 80000504/1", pc_o, fetch_err); end
      s_rresp = 2'b00; id_ready = 1;
      @(posedge clk); #1;
      id_ready = 0;
      for (int i = 0; i < 20 && !if_valid; i++) begin @(posedge clk); #1; end
      n_cmp++; if (pc_o !== 32'h8000_0508 || fetch_err !== 1'b0) begin n_bad++; $display("FAIL err_clear got %h/%b exp 80000508/0", pc_o, fetch_err); end
      id_ready = 1; s_rdelay = 3;
      for (int i = 0; i < 20 && !(axi.rready && !axi.rvalid); i++) begin @(posedge clk); #1; end
      rst = 0;
      #1;
      n_cmp++; if (axi.arvalid !== 1'b0 || axi.rready !== 1'b0 || if_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_outs got ar %b r %b v %b exp 0 0 0", axi.arvalid, axi.rready, if_valid); end
      n_cmp++; if (axi.araddr !== 32'h8000_0000) begin n_bad++; $display("FAIL midreset_araddr got %h exp 80000000", axi.araddr); end
      s_rdelay = 0;
      @(posedge clk); #1;
      ar_q.delete(); hs_pc.delete(); hs_inst.delete(); hs_cyc.delete();
      rst = 1;
      for (int i = 0; i < 20 && hs_pc.size() < 1; i++) begin @(posedge clk); #1; end
      n_cmp++; if (ar_q.size() < 1 || ar_q[0] !== 32'h8000_0000) begin n_bad++; $display("FAIL restart_ar got %h exp 80000000", (ar_q.size() > 0) ? ar_q[0] : 32'hx); end
      n_cmp++; if (hs_pc.size() < 1 || hs_pc[0] !== 32'h8000_0000) begin n_bad++; $display("FAIL restart_handoff got %h exp 80000000", (hs_pc.size() > 0) ? hs_pc[0] : 32'hx); end
   endtask

   initial begin
      n_cmp = 0; n_bad = 0; cyc = 0;
      test_reset();
      test_stream();
      test_stall();
      test_kill_in_r();
      test_prio();
      test_ar_stall();
      test_err_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
